// File: rtl/radix2_seq_divider.sv
// ----------------------------------------------------------------------------
// radix2_seq_divider
//   Iterative radix-2 restoring divider core for the RV32M divide unit.
//   Produces one quotient bit per enabled cycle. A sign-fixup cycle follows,
//   and then a registered one-cycle finished pulse. The upstream wrapper
//   filters out divide-by-zero and signed overflow. Divide-by-zero is still
//   well defined here: the quotient magnitude is all ones and the remainder
//   is |dividend|.
//
//   Optional build macro: DIV_EARLY_TERM_EN
//     When defined, the dividend magnitude is pre-normalised by its leading
//     zero count. Only the significant bits are then iterated.
//
// Ports
//   CLK          in   1         clock
//   nRST         in   1         async reset, active-low
//   i_start      in   1         latch operands and begin a divide (restarts if busy)
//   i_ena        in   1         iteration enable; low stalls in place
//   i_flush      in   1         abort current op, return to idle, no finished pulse
//   i_is_signed  in   1         operands are two's complement (sampled with start)
//   i_dividend   in   NUM_BITS  sampled with start
//   i_divisor    in   NUM_BITS  sampled with start
//   o_busy       out  1         high while iterating or fixing up signs
//   o_finished   out  1         one-cycle pulse; results valid that cycle
//   o_quotient   out  NUM_BITS  held from finished until the next result
//   o_remainder  out  NUM_BITS  held from finished until the next result
// ----------------------------------------------------------------------------
module radix2_seq_divider #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                i_start,
  input  logic                i_ena,
  input  logic                i_flush,
  input  logic                i_is_signed,
  input  logic [NUM_BITS-1:0] i_dividend,
  input  logic [NUM_BITS-1:0] i_divisor,
  output logic                o_busy,
  output logic                o_finished,
  output logic [NUM_BITS-1:0] o_quotient,
  output logic [NUM_BITS-1:0] o_remainder
);

  localparam int unsigned W     = NUM_BITS;
  localparam int unsigned PW    = NUM_BITS + 1;
  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t           r_state,  w_nxt_state;
  logic [CNT_W-1:0] r_count,  w_nxt_count;
  logic [PW-1:0]    r_prem,   w_nxt_prem;
  logic [W-1:0]     r_dvd,    w_nxt_dvd;
  logic [W-1:0]     r_dvs,    w_nxt_dvs;
  logic             r_q_neg,  w_nxt_q_neg;
  logic             r_r_neg,  w_nxt_r_neg;
  logic             w_nxt_busy;
  logic             w_nxt_finished;
  logic [W-1:0]     w_nxt_quotient;
  logic [W-1:0]     w_nxt_remainder;

  // Operand signs and magnitudes. The magnitude of the most negative value
  // is exact because the magnitude is held as W-bit unsigned.
  logic         w_sd, w_sv;
  logic [W-1:0] w_dd_mag, w_dv_mag;

  assign w_sd     = i_is_signed & i_dividend[W-1];
  assign w_sv     = i_is_signed & i_divisor[W-1];
  assign w_dd_mag = w_sd ? (-i_dividend) : i_dividend;
  assign w_dv_mag = w_sv ? (-i_divisor)  : i_divisor;

  // One restoring step. The partial remainder is one bit wider than the
  // divisor, so the shifted value always compares correctly.
  logic [PW-1:0] w_prem_sh;
  logic          w_ge;

  assign w_prem_sh = (r_prem << 1) | PW'(r_dvd[W-1]);
  assign w_ge      = (w_prem_sh >= {1'b0, r_dvs});

`ifdef DIV_EARLY_TERM_EN
  // Leading-zero count of the dividend magnitude. The result is W when the
  // magnitude is zero.
  function automatic logic [CNT_W-1:0] f_lzc(input logic [W-1:0] v);
    logic [CNT_W-1:0] lz;
    lz = CNT_W'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (v[i]) lz = CNT_W'(int'(W) - 1 - i);
    end
    return lz;
  endfunction

  // A zero divisor keeps the full iteration count. This lets it produce the
  // same all-ones quotient as the fixed-latency build.
  logic [CNT_W-1:0] w_lz;
  assign w_lz = (w_dv_mag == '0) ? '0 : f_lzc(w_dd_mag);
`endif

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      o_busy      <= 1'b0;
      o_finished  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_count     <= w_nxt_count;
      r_prem      <= w_nxt_prem;
      r_dvd       <= w_nxt_dvd;
      r_dvs       <= w_nxt_dvs;
      r_q_neg     <= w_nxt_q_neg;
      r_r_neg     <= w_nxt_r_neg;
      o_busy      <= w_nxt_busy;
      o_finished  <= w_nxt_finished;
      o_quotient  <= w_nxt_quotient;
      o_remainder <= w_nxt_remainder;
    end
  end

  // Next-state and datapath logic. Priority is flush > start > ena.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_count     = r_count;
    w_nxt_prem      = r_prem;
    w_nxt_dvd       = r_dvd;
    w_nxt_dvs       = r_dvs;
    w_nxt_q_neg     = r_q_neg;
    w_nxt_r_neg     = r_r_neg;
    w_nxt_finished  = 1'b0;
    w_nxt_quotient  = o_quotient;
    w_nxt_remainder = o_remainder;

    if (i_flush) begin
      w_nxt_state = S_IDLE;
    end else if (i_start) begin
      // Loading a new op also abandons any op in progress, without a pulse.
      w_nxt_state = S_ITER;
      w_nxt_prem  = '0;
      w_nxt_dvs   = w_dv_mag;
      w_nxt_q_neg = w_sd ^ w_sv;
      w_nxt_r_neg = w_sd;
`ifdef DIV_EARLY_TERM_EN
      w_nxt_dvd   = w_dd_mag << w_lz;
      w_nxt_count = (w_lz == CNT_W'(W)) ? CNT_W'(1) : (CNT_W'(W) - w_lz);
`else
      w_nxt_dvd   = w_dd_mag;
      w_nxt_count = CNT_W'(W);
`endif
    end else begin
      case (r_state)
        S_ITER: begin
          if (i_ena) begin
            // The dividend register fills from the LSB with quotient bits.
            w_nxt_prem  = w_ge ? (w_prem_sh - {1'b0, r_dvs}) : w_prem_sh;
            w_nxt_dvd   = {r_dvd[W-2:0], w_ge};
            w_nxt_count = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) w_nxt_state = S_FIXUP;
          end
        end
        S_FIXUP: begin
          w_nxt_quotient  = r_q_neg ? (-r_dvd) : r_dvd;
          w_nxt_remainder = r_r_neg ? (-r_prem[W-1:0]) : r_prem[W-1:0];
          w_nxt_finished  = 1'b1;
          w_nxt_state     = S_IDLE;
        end
        default: begin
        end
      endcase
    end

    w_nxt_busy = (w_nxt_state != S_IDLE);
  end

endmodule

// File: tb/tb_radix2_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_radix2_seq_divider
//   Directed self-checking bench for radix2_seq_divider.
//   Expected results and latencies are hand-computed. Each vector carries two
//   latencies: one for the fixed-latency build and one for the build with
//   DIV_EARLY_TERM_EN defined.
// ----------------------------------------------------------------------------
module tb_radix2_seq_divider;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         start;
  logic         ena;
  logic         flush;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         finished;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_tests = 0;
  int n_fail  = 0;

  radix2_seq_divider #(.NUM_BITS(W)) u_dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_start     (start),
    .i_ena       (ena),
    .i_flush     (flush),
    .i_is_signed (is_signed),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_finished  (finished),
    .o_quotient  (quotient),
    .o_remainder (remainder)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one divide and wait for its result. Call this at a negedge.
  // Latency counts edges from the start edge up to the edge that raises
  // finished.
  task automatic run_div(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input int lat_full, input int lat_early,
                         input int stall_at, input int stall_len);
    int lat;
    int n_busy;
    int exp_lat;
`ifdef DIV_EARLY_TERM_EN
    exp_lat = lat_early;
`else
    exp_lat = lat_full;
`endif
    start     = 1'b1;
    dividend  = dd;
    divisor   = dv;
    is_signed = sgn;
    @(negedge CLK);
    start     = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h1234_5678;
    is_signed = ~sgn;
    n_busy    = busy ? 1 : 0;
    lat       = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      if (finished) begin
        lat = n;
        break;
      end
      if (busy) n_busy++;
      if (n == stall_at) ena = 1'b0;
      if (n == stall_at + stall_len) ena = 1'b1;
    end
    ena = 1'b1;
    chk({tag, "_lat"},  32'(lat),    32'(exp_lat));
    chk({tag, "_busy"}, 32'(n_busy), 32'(exp_lat));
    chk({tag, "_q"},    quotient,    eq);
    chk({tag, "_r"},    remainder,   er);
    @(negedge CLK);
    chk({tag, "_pulse"}, 32'(finished), 32'd0);
  endtask

  // Count finished pulses over a window of cycles.
  task automatic count_fin(input int cycles, output int fins);
    fins = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge CLK);
      if (finished) fins++;
    end
  endtask

  initial begin
    int fins;
    nRST      = 1'b0;
    start     = 1'b0;
    ena       = 1'b1;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_fin",  32'(finished), 32'd0);
    chk("rst_q",    quotient,      32'd0);
    chk("rst_r",    remainder,     32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    //      tag         dividend      divisor       sgn   q             r             full early stall
    run_div("u100_7",   32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        33, 8,  0, 0);
    run_div("sm7_2",    32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 4,  0, 0);
    run_div("s7_m2",    32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        33, 4,  0, 0);
    run_div("smin_1",   32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        33, 33, 0, 0);
    run_div("u0_5",     32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        33, 2,  0, 0);
    run_div("umax_10",  32'hFFFFFFFF, 32'd10,       1'b0, 32'h19999999, 32'd5,        33, 33, 0, 0);
    run_div("u_dz",     32'd12345,    32'd0,        1'b0, 32'hFFFFFFFF, 32'd12345,    33, 33, 0, 0);
    run_div("s_dz",     32'hFFFFFF9C, 32'd0,        1'b1, 32'd1,        32'hFFFFFF9C, 33, 33, 0, 0);
    run_div("sm100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 33, 8,  0, 0);
    run_div("umin_max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 33, 33, 0, 0);
    run_div("stall",    32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        38, 13, 3, 5);

    // Flush mid-iteration: no pulse, results from the previous op are held.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    count_fin(40, fins);
    chk("flush_nofin", 32'(fins), 32'd0);
    chk("flush_hold_q", quotient, 32'd14);

    // Flush together with start: the start is ignored.
    start = 1'b1; flush = 1'b1;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    count_fin(40, fins);
    chk("flush_start_nofin", 32'(fins), 32'd0);

    // Reset mid-operation: outputs clear and no pulse follows.
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy),     32'd0);
    chk("mrst_fin",  32'(finished), 32'd0);
    chk("mrst_q",    quotient,      32'd0);
    chk("mrst_r",    remainder,     32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    count_fin(40, fins);
    chk("mrst_nofin", 32'(fins), 32'd0);

    // Restart while busy: only the second op completes.
    start = 1'b1; dividend = 32'hFFFFFFFF; divisor = 32'd3; is_signed = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    count_fin(4, fins);
    chk("restart_nofin", 32'(fins), 32'd0);
    run_div("restart", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 33, 11, 0, 0);
    count_fin(40, fins);
    chk("restart_noold", 32'(fins), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
